mux_nto1_scan: RTL and testbench

- Parametrised N-channel, WIDTH-bit multiplexer with a registered output. It is the successor to the fixed 4-to-1 single-bit tree mux.
- Two modes:
  - manual: the sel port picks the channel.
  - scan: an internal round-robin pointer steps through the channels enabled in ch_mask, holding each one for DWELL cycles.
- Used as a time-division channel selector that feeds single-lane downstream logic.

---
 rtl/mux_nto1_scan.sv | 130 +++++++++++++
 tb/tb_mux_nto1_scan.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_scan.sv
// N-channel, WIDTH-bit registered multiplexer with manual select and a
// round-robin scan mode that dwells DWELL cycles on each enabled channel.
module mux_nto1_scan #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int DWELL = 1,
  parameter int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N*WIDTH-1:0]   data_in,
  input  logic [SEL_W-1:0]     sel,
  input  logic                 mode,
  input  logic                 en,
  input  logic [N-1:0]         ch_mask,
  output logic [WIDTH-1:0]     y,
  output logic [SEL_W-1:0]     y_sel,
  output logic                 y_valid,
  output logic                 wrap
);

  localparam int DW_W = $clog2(DWELL + 1);
  localparam logic [DW_W-1:0] DWELL_C = DW_W'(DWELL);

  typedef enum logic {ST_MAN, ST_SCAN} state_t;

  state_t            r_state, w_state;
  logic [WIDTH-1:0]  r_y, w_y;
  logic [SEL_W-1:0]  r_ysel, w_ysel;
  logic              r_valid, w_valid;
  logic              r_wrap, w_wrap;
  logic [SEL_W-1:0]  r_ptr, w_ptr;
  logic [DW_W-1:0]   r_dwell, w_dwell;
  logic [SEL_W-1:0]  w_low, w_nxt, w_j;

  // Compare against every legal index so out-of-range selects yield zero.
  function automatic logic [WIDTH-1:0] chan(input logic [N*WIDTH-1:0] d,
                                            input logic [SEL_W-1:0]   idx);
    chan = '0;
    for (int k = 0; k < N; k++)
      if (idx == SEL_W'(k)) chan = d[k*WIDTH +: WIDTH];
  endfunction

  always_comb begin
    w_low = '0;
    for (int k = N - 1; k >= 0; k--)
      if (ch_mask[k]) w_low = SEL_W'(k);
  end

  // Circular search after r_ptr; smallest offset wins, offset N is r_ptr itself.
  always_comb begin
    w_nxt = r_ptr;
    w_j   = '0;
    for (int i = N; i >= 1; i--) begin
      w_j = SEL_W'((int'(r_ptr) + i) % N);
      if (ch_mask[w_j]) w_nxt = w_j;
    end
  end

  always_comb begin
    w_state = r_state;
    w_y     = r_y;
    w_ysel  = r_ysel;
    w_valid = 1'b0;
    w_wrap  = 1'b0;
    w_ptr   = r_ptr;
    w_dwell = r_dwell;
    if (en) begin
      if (!mode) begin
        w_state = ST_MAN;
        w_ysel  = sel;
        if (int'(sel) < N) begin
          w_y     = chan(data_in, sel);
          w_valid = 1'b1;
        end else begin
          w_y = '0;
        end
      end else if (ch_mask == '0) begin
        w_state = ST_SCAN;
        w_y     = '0;
        w_dwell = '0;
      end else if (r_state == ST_MAN || r_dwell == '0) begin
        w_state = ST_SCAN;
        w_ptr   = w_low;
        w_ysel  = w_low;
        w_y     = chan(data_in, w_low);
        w_valid = 1'b1;
        w_dwell = DW_W'(1);
      end else if (!ch_mask[r_ptr] || r_dwell == DWELL_C) begin
        w_ptr   = w_nxt;
        w_ysel  = w_nxt;
        w_y     = chan(data_in, w_nxt);
        w_valid = 1'b1;
        w_dwell = DW_W'(1);
        w_wrap  = (w_nxt <= r_ptr);
      end else begin
        w_ysel  = r_ptr;
        w_y     = chan(data_in, r_ptr);
        w_valid = 1'b1;
        w_dwell = r_dwell + DW_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_MAN;
      r_y     <= '0;
      r_ysel  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_ptr   <= '0;
      r_dwell <= '0;
    end else begin
      r_state <= w_state;
      r_y     <= w_y;
      r_ysel  <= w_ysel;
      r_valid <= w_valid;
      r_wrap  <= w_wrap;
      r_ptr   <= w_ptr;
      r_dwell <= w_dwell;
    end
  end

  assign y       = r_y;
  assign y_sel   = r_ysel;
  assign y_valid = r_valid;
  assign wrap    = r_wrap;

endmodule

// File: tb/tb_mux_nto1_scan.sv
// Scoreboard bench: A = N4/DWELL2, B = N5/DWELL1, C = N4/DWELL4.
module tb_mux_nto1_scan;
  localparam int DA = 0, DB = 1, DC = 2;

  logic        clk = 1'b0;
  logic        rst, en, mode;
  logic [31:0] d4;
  logic [39:0] d5;
  logic [1:0]  sel_a;
  logic [2:0]  sel_b;
  logic [3:0]  m_a, m_c;
  logic [4:0]  m_b;
  logic [7:0]  ya, yb, yc;
  logic [1:0]  sa, sc;
  logic [2:0]  sb;
  logic        va, vb, vc, wa, wb, wc;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  int          q_dut[$];
  logic [12:0] q_exp[$];
  int          q_tag[$];
  string       q_name[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mux_nto1_scan #(.WIDTH(8), .N(4), .DWELL(2)) u_a (
    .clk(clk), .rst(rst), .data_in(d4), .sel(sel_a), .mode(mode), .en(en),
    .ch_mask(m_a), .y(ya), .y_sel(sa), .y_valid(va), .wrap(wa));
  mux_nto1_scan #(.WIDTH(8), .N(5), .DWELL(1)) u_b (
    .clk(clk), .rst(rst), .data_in(d5), .sel(sel_b), .mode(mode), .en(en),
    .ch_mask(m_b), .y(yb), .y_sel(sb), .y_valid(vb), .wrap(wb));
  mux_nto1_scan #(.WIDTH(8), .N(4), .DWELL(4)) u_c (
    .clk(clk), .rst(rst), .data_in(d4), .sel(sel_a), .mode(mode), .en(en),
    .ch_mask(m_c), .y(yc), .y_sel(sc), .y_valid(vc), .wrap(wc));

  task automatic expect_out(input int d, input logic [7:0] ey, input logic [2:0] es,
                            input logic ev, input logic ew, input string nm);
    q_dut.push_back(d);
    q_exp.push_back({ey, es, ev, ew});
    q_tag.push_back(cyc + 1);
    q_name.push_back(nm);
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  // Monitor: pops every expectation whose edge has already happened.
  initial begin
    forever begin
      @(negedge clk);
      while (q_tag.size() > 0 && q_tag[0] <= cyc) begin
        int          d;
        logic [12:0] e, g;
        string       nm;
        d  = q_dut.pop_front();
        e  = q_exp.pop_front();
        nm = q_name.pop_front();
        void'(q_tag.pop_front());
        case (d)
          DA:      g = {ya, 1'b0, sa, va, wa};
          DB:      g = {yb, sb, vb, wb};
          default: g = {yc, 1'b0, sc, vc, wc};
        endcase
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL %s: got y=%h sel=%0d v=%b w=%b, expected y=%h sel=%0d v=%b w=%b",
                   nm, g[12:5], g[4:2], g[1], g[0], e[12:5], e[4:2], e[1], e[0]);
        end
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; mode = 1'b0;
    d4 = 32'h44332211; d5 = 40'h5544332211;
    sel_a = 2'd0; sel_b = 3'd0; m_a = 4'b0; m_b = 5'b0; m_c = 4'b0;
    expect_out(DA, 8'h00, 3'd0, 1'b0, 1'b0, "rst_a");
    expect_out(DB, 8'h00, 3'd0, 1'b0, 1'b0, "rst_b");
    expect_out(DC, 8'h00, 3'd0, 1'b0, 1'b0, "rst_c");
    tick;

    rst = 1'b0; en = 1'b1; sel_a = 2'd2; sel_b = 3'd2;
    expect_out(DA, 8'h33, 3'd2, 1'b1, 1'b0, "man_sel2");
    expect_out(DB, 8'h33, 3'd2, 1'b1, 1'b0, "man_b_sel2");
    tick;
    sel_a = 2'd0; sel_b = 3'd6;
    expect_out(DA, 8'h11, 3'd0, 1'b1, 1'b0, "man_sel0");
    expect_out(DB, 8'h00, 3'd6, 1'b0, 1'b0, "oob_sel6");
    tick;
    sel_b = 3'd4;
    expect_out(DB, 8'h55, 3'd4, 1'b1, 1'b0, "man_sel_last");
    expect_out(DC, 8'h11, 3'd0, 1'b1, 1'b0, "man_c");
    tick;
    en = 1'b0;
    expect_out(DA, 8'h11, 3'd0, 1'b0, 1'b0, "man_hold");
    expect_out(DB, 8'h55, 3'd4, 1'b0, 1'b0, "man_b_hold");
    tick;

    en = 1'b1; mode = 1'b1; m_a = 4'b1011; m_c = 4'b1010;
    expect_out(DA, 8'h11, 3'd0, 1'b1, 1'b0, "scan1");
    expect_out(DC, 8'h22, 3'd1, 1'b1, 1'b0, "c_entry");
    tick;
    expect_out(DA, 8'h11, 3'd0, 1'b1, 1'b0, "scan2");
    expect_out(DC, 8'h22, 3'd1, 1'b1, 1'b0, "c_dwell2");
    tick;
    m_c = 4'b1000;
    expect_out(DA, 8'h22, 3'd1, 1'b1, 1'b0, "scan3");
    expect_out(DC, 8'h44, 3'd3, 1'b1, 1'b0, "c_masked");
    tick;
    expect_out(DA, 8'h22, 3'd1, 1'b1, 1'b0, "scan4");
    expect_out(DC, 8'h44, 3'd3, 1'b1, 1'b0, "c_after_mask");
    tick;
    m_c = 4'b0000;
    expect_out(DA, 8'h44, 3'd3, 1'b1, 1'b0, "scan5");
    expect_out(DC, 8'h00, 3'd3, 1'b0, 1'b0, "c_empty");
    tick;
    m_c = 4'b0100;
    expect_out(DA, 8'h44, 3'd3, 1'b1, 1'b0, "scan6");
    expect_out(DC, 8'h33, 3'd2, 1'b1, 1'b0, "c_restore");
    tick;
    expect_out(DA, 8'h11, 3'd0, 1'b1, 1'b1, "scan7_wrap");
    expect_out(DC, 8'h33, 3'd2, 1'b1, 1'b0, "c_d2");
    tick;
    expect_out(DA, 8'h11, 3'd0, 1'b1, 1'b0, "scan8");
    expect_out(DC, 8'h33, 3'd2, 1'b1, 1'b0, "c_d3");
    tick;

    en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      expect_out(DA, 8'h11, 3'd0, 1'b0, 1'b0, "en_hold_a");
      expect_out(DC, 8'h33, 3'd2, 1'b0, 1'b0, "en_hold_c");
      tick;
    end
    en = 1'b1;
    expect_out(DA, 8'h22, 3'd1, 1'b1, 1'b0, "resume_a");
    expect_out(DC, 8'h33, 3'd2, 1'b1, 1'b0, "resume_c");
    tick;
    expect_out(DA, 8'h22, 3'd1, 1'b1, 1'b0, "scan_a13");
    expect_out(DC, 8'h33, 3'd2, 1'b1, 1'b1, "c_wrap1");
    tick;
    expect_out(DA, 8'h44, 3'd3, 1'b1, 1'b0, "scan_a14");
    expect_out(DC, 8'h33, 3'd2, 1'b1, 1'b0, "c_nowrap14");
    tick;
    expect_out(DA, 8'h44, 3'd3, 1'b1, 1'b0, "scan_a15");
    expect_out(DC, 8'h33, 3'd2, 1'b1, 1'b0, "c_nowrap15");
    tick;
    expect_out(DA, 8'h11, 3'd0, 1'b1, 1'b1, "scan_a16_wrap");
    expect_out(DC, 8'h33, 3'd2, 1'b1, 1'b0, "c_nowrap16");
    tick;
    d4 = 32'h443322A5;
    expect_out(DA, 8'hA5, 3'd0, 1'b1, 1'b0, "live_data");
    expect_out(DC, 8'h33, 3'd2, 1'b1, 1'b1, "c_wrap2");
    tick;

    rst = 1'b1;
    expect_out(DA, 8'h00, 3'd0, 1'b0, 1'b0, "rst_mid_a");
    expect_out(DB, 8'h00, 3'd0, 1'b0, 1'b0, "rst_mid_b");
    expect_out(DC, 8'h00, 3'd0, 1'b0, 1'b0, "rst_mid_c");
    tick;
    rst = 1'b0;
    expect_out(DA, 8'hA5, 3'd0, 1'b1, 1'b0, "reentry_a");
    expect_out(DC, 8'h33, 3'd2, 1'b1, 1'b0, "reentry_c");
    tick;
    mode = 1'b0; sel_a = 2'd3;
    expect_out(DA, 8'h44, 3'd3, 1'b1, 1'b0, "to_manual");
    tick;
    mode = 1'b1;
    expect_out(DA, 8'hA5, 3'd0, 1'b1, 1'b0, "back_to_scan");
    tick;

    for (int i = 0; i < 10 && q_tag.size() > 0; i++) tick;
    if (q_tag.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", q_tag.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
